// File: rtl/tx_scheduler.sv
// Byte FIFO feeding a UART transmitter: one launch per frame, waits for the
// transmitter's done pulse, and signals completion once the queue runs dry.
module tx_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_i,
    input  logic [7:0]                 wr_data_i,
    input  logic                       flush_i,
    input  logic                       ovf_clr_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       ovf_o,
    output logic                       busy_o,
    output logic                       txc_o,
    output logic                       tx_transmit_o,
    output logic [7:0]                 tx_data_o,
    input  logic                       tx_done_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t          state_r;
    logic [7:0]      mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [LW-1:0]   count_r;
    logic            ovf_r;
    logic            txc_r;
    logic            tx_transmit_r;
    logic [7:0]      tx_data_r;

    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;
    logic            drop_s;

    // Queue status and transfer qualifiers, all derived from registered state.
    always_comb begin
        full_s  = 1'b0;
        empty_s = 1'b0;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        drop_s  = 1'b0;
        if (count_r == LVL_FULL) begin
            full_s = 1'b1;
        end else begin
            full_s = 1'b0;
        end
        if (count_r == {LW{1'b0}}) begin
            empty_s = 1'b1;
        end else begin
            empty_s = 1'b0;
        end
        push_s = wr_i & ~full_s & ~flush_i;
        // A write into a full queue is lost even when a pop frees a slot this cycle.
        drop_s = wr_i & full_s & ~flush_i;
        if (state_r == ST_IDLE) begin
            pop_s = ~empty_s & ~flush_i;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data_i;
        end
    end

    // Pointers, level, overflow flag and the launch/wait state machine.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r       <= ST_IDLE;
            wr_ptr_r      <= {PW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            count_r       <= {LW{1'b0}};
            ovf_r         <= 1'b0;
            txc_r         <= 1'b0;
            tx_transmit_r <= 1'b0;
            tx_data_r     <= 8'h00;
        end else begin
            tx_transmit_r <= 1'b0;
            txc_r         <= 1'b0;
            if (flush_i) begin
                wr_ptr_r <= {PW{1'b0}};
                rd_ptr_r <= {PW{1'b0}};
                count_r  <= {LW{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
                count_r <= count_r + LW'(push_s) - LW'(pop_s);
            end
            // Setting wins over a simultaneous clear.
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        tx_data_r     <= mem_r[rd_ptr_r];
                        tx_transmit_r <= 1'b1;
                        state_r       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (tx_done_i) begin
                        state_r <= ST_IDLE;
                        txc_r   <= empty_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign full_o        = full_s;
    assign empty_o       = empty_s;
    assign level_o       = count_r;
    assign ovf_o         = ovf_r;
    assign busy_o        = (state_r == ST_WAIT);
    assign txc_o         = txc_r;
    assign tx_transmit_o = tx_transmit_r;
    assign tx_data_o     = tx_data_r;

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler: expected launch bytes are queued when
// written and compared when the scheduler launches them.
module tb_tx_scheduler;

    localparam int DEPTH = 4;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          wr_i = 1'b0;
    logic [7:0]    wr_data_i = 8'h00;
    logic          flush_i = 1'b0;
    logic          ovf_clr_i = 1'b0;
    logic          full_o;
    logic          empty_o;
    logic [LW-1:0] level_o;
    logic          ovf_o;
    logic          busy_o;
    logic          txc_o;
    logic          tx_transmit_o;
    logic [7:0]    tx_data_o;
    logic          tx_done_i = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int n_launch = 0;
    int txc_cnt = 0;
    logic [7:0] sb [$];

    tx_scheduler #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .wr_i(wr_i), .wr_data_i(wr_data_i),
        .flush_i(flush_i), .ovf_clr_i(ovf_clr_i), .full_o(full_o),
        .empty_o(empty_o), .level_o(level_o), .ovf_o(ovf_o), .busy_o(busy_o),
        .txc_o(txc_o), .tx_transmit_o(tx_transmit_o), .tx_data_o(tx_data_o),
        .tx_done_i(tx_done_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then inspect outputs 1ns later.
    task automatic tick();
        logic [7:0] e;
        @(posedge clk_i);
        #1;
        if (txc_o) txc_cnt++;
        if (tx_transmit_o) begin
            n_launch++;
            if (sb.size() == 0) begin
                chk("spurious_launch", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("launch_data", {24'h0, tx_data_o}, {24'h0, e});
            end
        end
    endtask

    task automatic wr_byte(input logic [7:0] d, input bit accept);
        wr_i = 1'b1;
        wr_data_i = d;
        tick();
        wr_i = 1'b0;
        if (accept) sb.push_back(d);
    endtask

    // Complete the frame in flight after gap cycles, then give the next launch its edge.
    task automatic one_frame(input int gap);
        bit last;
        repeat (gap) tick();
        last = (sb.size() == 0);
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        chk("txc_at_done", {31'h0, txc_o}, {31'h0, last});
        tick();
    endtask

    task automatic drain(input int gap);
        int guard = 0;
        while (busy_o && guard < 20) begin
            one_frame(gap);
            guard++;
        end
        chk("drain_idle", {31'h0, busy_o}, 32'd0);
        chk("drain_sb_empty", sb.size(), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_level"}, {29'h0, level_o}, 32'd0);
        chk({tag, "_empty"}, {31'h0, empty_o}, 32'd1);
        chk({tag, "_full"}, {31'h0, full_o}, 32'd0);
        chk({tag, "_ovf"}, {31'h0, ovf_o}, 32'd0);
        chk({tag, "_busy"}, {31'h0, busy_o}, 32'd0);
        chk({tag, "_txc"}, {31'h0, txc_o}, 32'd0);
        chk({tag, "_transmit"}, {31'h0, tx_transmit_o}, 32'd0);
        chk({tag, "_data"}, {24'h0, tx_data_o}, 32'd0);
    endtask

    initial begin
        int base;
        #2;
        chk_reset_vals("reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        tick();

        // Single byte: launch two edges after the write, then completion.
        wr_byte(8'hA5, 1'b1);
        chk("single_level_after_push", {29'h0, level_o}, 32'd1);
        chk("single_no_early_launch", {31'h0, tx_transmit_o}, 32'd0);
        tick();
        chk("single_launch", {31'h0, tx_transmit_o}, 32'd1);
        chk("single_busy", {31'h0, busy_o}, 32'd1);
        chk("single_empty", {31'h0, empty_o}, 32'd1);
        tick();
        chk("single_pulse_width", {31'h0, tx_transmit_o}, 32'd0);
        chk("single_data_held", {24'h0, tx_data_o}, 32'hA5);
        one_frame(2);
        chk("single_idle", {31'h0, busy_o}, 32'd0);
        chk("single_txc_width", {31'h0, txc_o}, 32'd0);

        // Fill, overflow and overflow-clear race.
        base = n_launch;
        for (int i = 1; i <= 5; i++) wr_byte(8'(i), 1'b1);
        chk("fill_one_launch", n_launch - base, 32'd1);
        chk("fill_level", {29'h0, level_o}, 32'd4);
        chk("fill_full", {31'h0, full_o}, 32'd1);
        chk("fill_no_ovf", {31'h0, ovf_o}, 32'd0);
        wr_byte(8'h06, 1'b0);
        chk("ovf_set", {31'h0, ovf_o}, 32'd1);
        chk("ovf_level", {29'h0, level_o}, 32'd4);
        ovf_clr_i = 1'b1;
        wr_byte(8'h07, 1'b0);
        chk("ovf_race_set_wins", {31'h0, ovf_o}, 32'd1);
        tick();
        ovf_clr_i = 1'b0;
        chk("ovf_cleared", {31'h0, ovf_o}, 32'd0);
        drain(1);
        chk("fill_drained_level", {29'h0, level_o}, 32'd0);

        // Ordering across pointer wrap, done returned 20 cycles after launch.
        base = txc_cnt;
        for (int i = 0; i < 5; i++) wr_byte(8'(i), 1'b1);
        for (int i = 5; i < 10; i++) begin
            one_frame(20);
            wr_byte(8'(i), 1'b1);
        end
        drain(20);
        chk("order_single_txc", txc_cnt - base, 32'd1);

        // Flush while a frame is in flight.
        for (int i = 0; i < 4; i++) wr_byte(8'hB0 + 8'(i), 1'b1);
        chk("flush_pre_level", {29'h0, level_o}, 32'd3);
        flush_i = 1'b1;
        wr_byte(8'hEE, 1'b0);
        flush_i = 1'b0;
        repeat (3) void'(sb.pop_back());
        chk("flush_level", {29'h0, level_o}, 32'd0);
        chk("flush_empty", {31'h0, empty_o}, 32'd1);
        chk("flush_ovf_unchanged", {31'h0, ovf_o}, 32'd0);
        chk("flush_busy_kept", {31'h0, busy_o}, 32'd1);
        base = n_launch;
        one_frame(5);
        repeat (4) tick();
        chk("flush_no_launch", n_launch - base, 32'd0);

        // Asynchronous reset between edges during a frame with two queued.
        for (int i = 0; i < 3; i++) wr_byte(8'hC0 + 8'(i), 1'b1);
        chk("arst_pre_level", {29'h0, level_o}, 32'd2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_reset_vals("arst");
        sb.delete();
        tick();
        rst_ni = 1'b1;
        base = n_launch;
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        chk("arst_stray_done_txc", {31'h0, txc_o}, 32'd0);
        repeat (4) tick();
        chk("arst_no_launch", n_launch - base, 32'd0);
        chk("arst_idle", {31'h0, busy_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
